// File: rtl/alu_byte_sequencer.sv
// Byte-serial sequencer for the 32-bit FP ALU core: 8 operand bytes in, start/done with the core, 5 bytes out.
// Latency: core_start the cycle after the 8th byte; result byte 0 valid the cycle after core_done (or timeout).
// Backpressure: out_valid/out_byte hold while out_ready=0; in_valid outside LOAD drops the byte and flags overrun.
module alu_byte_sequencer #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  input  logic [OP_W-1:0] in_op,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [31:0]     core_a,
  output logic [31:0]     core_b,
  output logic [OP_W-1:0] core_op,
  output logic            core_start,
  input  logic            core_done,
  input  logic [31:0]     core_result,
  input  logic [4:0]      core_flags
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      cnt;
  logic [TW-1:0]   timer;
  logic [31:0]     result;
  logic [7:0]      status;

  logic            accept;
  logic            timeout_hit;
  logic            out_xfer;
  logic            overrun_nxt;

  assign accept      = (state == S_LOAD) && in_valid;
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign out_xfer    = (state == S_UNLOAD) && out_ready;
  // Overrun is sticky; any byte offered outside LOAD joins the existing flag.
  assign overrun_nxt = status[6] | in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the outputs that follow directly from state/cnt.
  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    out_valid  = 1'b0;
    out_byte   = 8'h00;
    busy       = (state != S_LOAD) || (cnt != 3'd0);
    case (state)
      S_LOAD: begin
        if (accept && (cnt == 3'd7)) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done || timeout_hit) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        case (cnt)
          3'd0:    out_byte = result[7:0];
          3'd1:    out_byte = result[15:8];
          3'd2:    out_byte = result[23:16];
          3'd3:    out_byte = result[31:24];
          3'd4:    out_byte = status;
          default: out_byte = 8'h00;
        endcase
        if (out_xfer && (cnt == 3'd4)) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Operand assembly, timer, result/status capture and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      timer   <= '0;
      result  <= 32'h0;
      status  <= 8'h00;
      core_a  <= 32'h0;
      core_b  <= 32'h0;
      core_op <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (cnt[2]) core_b[{cnt[1:0], 3'b000} +: 8] <= in_byte;
            else        core_a[{cnt[1:0], 3'b000} +: 8] <= in_byte;
            if (cnt == 3'd0) begin
              core_op <= in_op;
              status  <= 8'h00;
            end
            cnt <= (cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          if (in_valid) status[6] <= 1'b1;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          // Done takes priority over a timeout landing in the same cycle.
          if (core_done) begin
            result <= core_result;
            status <= {1'b0, overrun_nxt, 1'b0, core_flags};
          end else if (timeout_hit) begin
            result <= 32'h0;
            status <= {1'b1, overrun_nxt, 6'b000000};
          end else if (in_valid) begin
            status[6] <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (in_valid) status[6] <= 1'b1;
          if (out_xfer) cnt <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer with a small behavioural core model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected bytes and wait counts come from the vector table below.
module tb_alu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = 3'd0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [2:0]  core_op;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [31:0] core_result = 32'h0;
  logic [4:0]  core_flags = 5'h0;

  int n_tests = 0;
  int n_fail  = 0;

  // Core model state: done fires core_delay cycles after start; -1 means never.
  int core_delay = -1;
  int cd = 0;

  alu_byte_sequencer #(.OP_W(3), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_byte(in_byte), .in_valid(in_valid), .in_op(in_op),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
    .core_a(core_a), .core_b(core_b), .core_op(core_op),
    .core_start(core_start), .core_done(core_done),
    .core_result(core_result), .core_flags(core_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          delay;
    logic [31:0] res;
    logic [4:0]  flags;
    bit          ov;
    int          stall;
    int          exp_wait;
    logic [39:0] exp;     // bytes in output order, first byte in [39:32]
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and update the core model.
  task automatic step();
    @(negedge clk);
    core_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) core_done = 1'b1;
    end
    if (core_start && core_delay > 0) cd = core_delay;
  endtask

  task automatic send_bytes(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [63:0] ops;
    ops = {b, a};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_byte  = ops[8*i +: 8];
      in_op    = (i == 0) ? op : ~op;
      step();
      if (i == 0) check("busy_after_first_byte", {39'h0, busy}, 40'h1);
      if (i < 7)  check("no_early_start", {39'h0, core_start}, 40'h0);
    end
    in_valid = 1'b0;
    in_op    = 3'd0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int waitc;
    logic [39:0] got;
    core_delay  = v.delay;
    core_result = v.res;
    core_flags  = v.flags;
    send_bytes(v.a, v.b, v.op);
    // Now in the cycle right after the 8th byte was accepted.
    check({tag, "_start"}, {39'h0, core_start}, 40'h1);
    check({tag, "_core_a"}, {8'h0, core_a}, {8'h0, v.a});
    check({tag, "_core_b"}, {8'h0, core_b}, {8'h0, v.b});
    check({tag, "_core_op"}, {37'h0, core_op}, {37'h0, v.op});
    waitc = 0;
    if (v.ov) begin
      in_valid = 1'b1;
      in_byte  = 8'hAA;
    end
    step();
    in_valid = 1'b0;
    check({tag, "_start_one_cycle"}, {39'h0, core_start}, 40'h0);
    while (!out_valid && waitc < 200) begin
      waitc++;
      step();
    end
    check({tag, "_wait_cycles"}, 40'(waitc), 40'(v.exp_wait));
    got = 40'h0;
    for (int k = 0; k < 5; k++) begin
      check({tag, "_out_valid"}, {39'h0, out_valid}, 40'h1);
      if (k == v.stall) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          check({tag, "_stall_valid"}, {39'h0, out_valid}, 40'h1);
          check({tag, "_stall_byte"}, {32'h0, out_byte}, {32'h0, v.exp[39-8*k -: 8]});
        end
        out_ready = 1'b1;
      end
      got[39-8*k -: 8] = out_byte;
      step();
    end
    check({tag, "_out_bytes"}, got, v.exp);
    check({tag, "_valid_drop"}, {39'h0, out_valid}, 40'h0);
    check({tag, "_busy_drop"}, {39'h0, busy}, 40'h0);
    check({tag, "_a_stable"}, {8'h0, core_a}, {8'h0, v.a});
    check({tag, "_b_stable"}, {8'h0, core_b}, {8'h0, v.b});
  endtask

  initial begin
    vecs[0] = '{a:32'h3F800000, b:32'h40000000, op:3'd0, delay:3,  res:32'h40400000, flags:5'h00,
                ov:1'b0, stall:2,  exp_wait:3,  exp:40'h00_00_40_40_00};
    vecs[1] = '{a:32'hC0A00000, b:32'h3F000000, op:3'd1, delay:-1, res:32'hDEADBEEF, flags:5'h1F,
                ov:1'b0, stall:-1, exp_wait:64, exp:40'h00_00_00_00_80};
    vecs[2] = '{a:32'h11223344, b:32'h55667788, op:3'd2, delay:3,  res:32'h00000000, flags:5'h04,
                ov:1'b1, stall:-1, exp_wait:3,  exp:40'h00_00_00_00_44};
    vecs[3] = '{a:32'h01020304, b:32'hA0B0C0D0, op:3'd5, delay:64, res:32'h12345678, flags:5'h00,
                ov:1'b0, stall:-1, exp_wait:64, exp:40'h78_56_34_12_00};
    vecs[4] = '{a:32'hFFFFFFFF, b:32'h80000001, op:3'd7, delay:1,  res:32'hA5A50F0F, flags:5'h1F,
                ov:1'b0, stall:-1, exp_wait:1,  exp:40'h0F_0F_A5_A5_1F};

    // Reset values.
    #12;
    check("rst_out_byte", {32'h0, out_byte}, 40'h0);
    check("rst_out_valid", {39'h0, out_valid}, 40'h0);
    check("rst_busy", {39'h0, busy}, 40'h0);
    check("rst_core_a", {8'h0, core_a}, 40'h0);
    check("rst_core_b", {8'h0, core_b}, 40'h0);
    check("rst_core_op", {37'h0, core_op}, 40'h0);
    check("rst_core_start", {39'h0, core_start}, 40'h0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      step();
    end

    // Reset during WAIT (with an overrun already flagged) aborts the transaction.
    core_delay = -1;
    send_bytes(32'hCAFEBABE, 32'h0BADF00D, 3'd3);
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("pre_rst_busy", {39'h0, busy}, 40'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {39'h0, busy}, 40'h0);
    check("mid_rst_out_valid", {39'h0, out_valid}, 40'h0);
    check("mid_rst_core_start", {39'h0, core_start}, 40'h0);
    check("mid_rst_core_a", {8'h0, core_a}, 40'h0);
    step();
    cd = 0;
    rst_n = 1'b1;
    step();
    vecs[0].stall = -1;
    run_txn(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
